// File: rtl/l1c_inst_assoc.sv
// l1c_inst_assoc: set-associative (1 or 2 way) L1 instruction cache.
//
// The cache sits between the core fetch port and the wrapper's AXI read
// channel. A hit returns one word per request. A miss refills the whole line
// with a burst. Each set has LRU replacement, and inv clears the whole cache
// in one cycle for fence.i.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   core_addr/core_req fetch address (word aligned) and request, sampled in IDLE
//   inv                whole-cache invalidate, sampled in IDLE, wins over core_req
//   stall_DM           holds a hit response in LOOKUP
//   core_out/core_wait fetched word; core_wait=0 marks core_out valid
//   I_req/I_addr       refill request and line-aligned refill address
//   I_out/RVALID/RLAST refill beat data, beat valid, last beat
//   hit_cnt/miss_cnt   statistics counters
//
// Optional feature macro: L1C_INST_STATS_EN. When it is defined, hit_cnt and
// miss_cnt are saturating counters. When it is undefined, both ports are
// tied to zero.
module l1c_inst_assoc #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_req,
  input  logic              inv,
  input  logic              stall_DM,
  output logic [DATA_W-1:0] core_out,
  output logic              core_wait,
  output logic              I_req,
  output logic [ADDR_W-1:0] I_addr,
  input  logic [DATA_W-1:0] I_out,
  input  logic              RVALID,
  input  logic              RLAST,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);

  localparam int OFF    = $clog2(LINE_WORDS * 4);
  localparam int IDX    = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF - IDX;
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int RA_W   = IDX + WSEL_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_REFILL    = 3'd2,
    S_FILL_DONE = 3'd3,
    S_INV       = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WSEL_W-1:0]   cnt_q, cnt_d;
  logic                victim_q, victim_d;
  logic [SETS-1:0]     valid_q [WAYS];
  logic [SETS-1:0]     valid_d [WAYS];
  logic [SETS-1:0]     lru_q, lru_d;

  logic [TAG_W-1:0]    tag_mem  [WAYS][SETS];
  logic [DATA_W-1:0]   data_mem [WAYS][SETS*LINE_WORDS];
  logic [TAG_W-1:0]    tag_rd_q [WAYS];
  logic [DATA_W-1:0]   data_rd_q[WAYS];

  logic [RA_W-1:0]     rd_addr_s;
  logic [IDX-1:0]      idx_s;
  logic [TAG_W-1:0]    tag_s;
  logic [ADDR_W-1:0]   line_addr_s;
  logic [WAYS-1:0]     hit_vec_s;
  logic                hit_s;
  logic                hit_way_s;
  logic                vic_s;
  logic                found_s;
  logic                tag_we_s;
  logic                data_we_s;

  // The byte-offset bits of a word-aligned fetch address carry no information.
  logic unused_addr_s;
  assign unused_addr_s = &{1'b0, core_addr[1:0]};

  // In IDLE the arrays read with the incoming request's {index, word}.
  // Otherwise they read with the latched address, which keeps a stalled hit
  // stable and lets FILL_DONE re-present the index.
  always_comb begin
    if (state_q == S_IDLE) begin
      rd_addr_s = core_addr[OFF+IDX-1:2];
    end else begin
      rd_addr_s = addr_q[OFF+IDX-1:2];
    end
  end

  assign idx_s       = addr_q[OFF+IDX-1:OFF];
  assign tag_s       = addr_q[ADDR_W-1:OFF+IDX];
  assign line_addr_s = {addr_q[ADDR_W-1:OFF], {OFF{1'b0}}};

  // Tag compare per way, then pick the hit way (lowest wins).
  always_comb begin
    hit_way_s = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec_s[w] = valid_q[w][idx_s] && (tag_rd_q[w] == tag_s);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec_s[w]) begin
        hit_way_s = 1'(w);
      end else begin
        hit_way_s = hit_way_s;
      end
    end
    hit_s = |hit_vec_s;
  end

  // Victim choice: the lowest invalid way first. If every way is valid, use
  // the LRU way.
  always_comb begin
    vic_s   = 1'b0;
    found_s = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found_s && !valid_q[w][idx_s]) begin
        vic_s   = 1'(w);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    if (!found_s && (WAYS == 2)) begin
      vic_s = lru_q[idx_s];
    end else begin
      vic_s = vic_s;
    end
  end

  // Main controller: next state, bookkeeping updates and the fetch/refill outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    victim_d  = victim_q;
    valid_d   = valid_q;
    lru_d     = lru_q;
    tag_we_s  = 1'b0;
    data_we_s = 1'b0;
    core_out  = {DATA_W{1'b0}};
    core_wait = 1'b1;
    I_req     = 1'b0;
    I_addr    = {ADDR_W{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (inv) begin
          state_d = S_INV;
        end else if (core_req) begin
          addr_d  = core_addr;
          state_d = S_LOOKUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOOKUP: begin
        if (hit_s) begin
          core_out  = data_rd_q[hit_way_s];
          core_wait = 1'b0;
          if (WAYS == 2) begin
            lru_d[idx_s] = ~hit_way_s;
          end else begin
            lru_d = lru_q;
          end
          state_d = stall_DM ? S_LOOKUP : S_IDLE;
        end else begin
          I_req              = 1'b1;
          I_addr             = line_addr_s;
          tag_we_s           = 1'b1;
          victim_d           = vic_s;
          valid_d[vic_s][idx_s] = 1'b0;
          cnt_d              = {WSEL_W{1'b0}};
          state_d            = S_REFILL;
        end
      end
      S_REFILL: begin
        I_req  = 1'b1;
        I_addr = line_addr_s;
        if (WAYS == 2) begin
          lru_d[idx_s] = ~victim_q;
        end else begin
          lru_d = lru_q;
        end
        if (RVALID) begin
          data_we_s = 1'b1;
          if (cnt_q != WSEL_W'(LINE_WORDS - 1)) begin
            cnt_d = cnt_q + WSEL_W'(1);
          end else begin
            cnt_d = cnt_q;
          end
          if (RLAST) begin
            // A short burst leaves the line invalid, so the re-lookup misses
            // and the line is fetched again.
            if (cnt_q == WSEL_W'(LINE_WORDS - 1)) begin
              valid_d[victim_q][idx_s] = 1'b1;
            end else begin
              valid_d[victim_q][idx_s] = 1'b0;
            end
            state_d = S_FILL_DONE;
          end else begin
            state_d = S_REFILL;
          end
        end else begin
          state_d = S_REFILL;
        end
      end
      S_FILL_DONE: begin
        state_d = S_LOOKUP;
      end
      S_INV: begin
        for (int w = 0; w < WAYS; w++) begin
          valid_d[w] = {SETS{1'b0}};
        end
        lru_d     = {SETS{1'b0}};
        core_wait = 1'b0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= {ADDR_W{1'b0}};
      cnt_q    <= {WSEL_W{1'b0}};
      victim_q <= 1'b0;
      lru_q    <= {SETS{1'b0}};
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= {SETS{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      victim_q <= victim_d;
      lru_q    <= lru_d;
      valid_q  <= valid_d;
    end
  end

  // Tag and data arrays: synchronous read with one cycle of latency, and
  // writes of one word at a time. Writes are blocked during reset, so a
  // reset in the middle of a refill drops the beat.
  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      tag_rd_q[w]  <= tag_mem[w][rd_addr_s[RA_W-1:WSEL_W]];
      data_rd_q[w] <= data_mem[w][rd_addr_s];
    end
    if (!rst && tag_we_s) begin
      tag_mem[vic_s][idx_s] <= tag_s;
    end
    if (!rst && data_we_s) begin
      data_mem[victim_q][{idx_s, cnt_q}] <= I_out;
    end
  end

`ifdef L1C_INST_STATS_EN
  logic        from_idle_q, from_idle_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Only a first lookup, entered from IDLE, counts as a hit. Stall-held
  // cycles and post-fill lookups do not. Both counters saturate.
  always_comb begin
    from_idle_d = (state_q == S_IDLE);
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (state_q == S_LOOKUP) begin
      if (hit_s && from_idle_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
        hit_cnt_d = hit_cnt_q + 32'd1;
      end else if (!hit_s && (miss_cnt_q != 32'hFFFF_FFFF)) begin
        miss_cnt_d = miss_cnt_q + 32'd1;
      end else begin
        hit_cnt_d = hit_cnt_q;
      end
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
  end

  // Statistics registers. inv does not clear them; rst does.
  always_ff @(posedge clk) begin
    if (rst) begin
      from_idle_q <= 1'b0;
      hit_cnt_q   <= 32'd0;
      miss_cnt_q  <= 32'd0;
    end else begin
      from_idle_q <= from_idle_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = 32'd0;
  assign miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_l1c_inst_assoc.sv
module tb_l1c_inst_assoc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] core_addr;
  logic        core_req;
  logic        inv;
  logic        stall_DM;
  logic [31:0] core_out;
  logic        core_wait;
  logic        I_req;
  logic [31:0] I_addr;
  logic [31:0] I_out;
  logic        RVALID;
  logic        RLAST;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: 2 ways, 64 sets, 16-byte lines.
  bit        m_valid [2][64];
  bit [21:0] m_tag   [2][64];
  bit        m_lru   [64];   // way to replace when both ways are valid
  int        exp_hit = 0;
  int        exp_miss = 0;

  always #5 clk = ~clk;

  l1c_inst_assoc dut (
    .clk(clk), .rst(rst), .core_addr(core_addr), .core_req(core_req),
    .inv(inv), .stall_DM(stall_DM), .core_out(core_out), .core_wait(core_wait),
    .I_req(I_req), .I_addr(I_addr), .I_out(I_out), .RVALID(RVALID),
    .RLAST(RLAST), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Backing memory contents: a fixed pattern at line 0x100, a hash elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0000010) mem_word = 32'h000000A0 + 32'(a[3:2]);
    else                        mem_word = (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic void model_clear();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 64; s++) m_valid[w][s] = 1'b0;
    for (int s = 0; s < 64; s++) m_lru[s] = 1'b0;
  endfunction

  function automatic int model_find(input logic [31:0] a);
    model_find = -1;
    for (int w = 1; w >= 0; w--)
      if (m_valid[w][a[9:4]] && m_tag[w][a[9:4]] == a[31:10]) model_find = w;
  endfunction

  // One fetch. The model decides hit or miss at each lookup and serves refills.
  task automatic do_fetch(input logic [31:0] a, input int early, input int stall_n,
                          input bit gaps, input bit noise,
                          output int n_ref, output int req_cyc);
    int  s, w, v, nb, gap, round;
    bit  done;
    logic [31:0] line;
    s = int'(a[9:4]);
    line = {a[31:4], 4'h0};
    n_ref = 0; req_cyc = 0; done = 1'b0; round = 0;
    core_addr = a; core_req = 1'b1;
    if (noise) begin RVALID = 1'b1; I_out = $urandom; end
    @(posedge clk); #1;
    core_req = 1'b0; RVALID = 1'b0;
    while (!done && round < 4) begin
      w = model_find(a);
      if (w >= 0) begin
        checks++;
        if (core_wait !== 1'b0 || core_out !== mem_word(a) || I_req !== 1'b0) begin
          errors++;
          $display("FAIL hit %h: wait=%b out=%h ireq=%b, expected wait=0 out=%h ireq=0",
                   a, core_wait, core_out, I_req, mem_word(a));
        end
        if (round == 0) exp_hit++;
        m_lru[s] = ~w[0];
        for (int k = 0; k < stall_n; k++) begin
          stall_DM = 1'b1;
          @(posedge clk); #1;
          checks++;
          if (core_wait !== 1'b0 || core_out !== mem_word(a)) begin
            errors++;
            $display("FAIL stall_hold %h cyc %0d: wait=%b out=%h, expected wait=0 out=%h",
                     a, k, core_wait, core_out, mem_word(a));
          end
        end
        stall_DM = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (core_wait !== 1'b1 || core_out !== 32'h0) begin
          errors++;
          $display("FAIL back_to_idle %h: wait=%b out=%h, expected wait=1 out=0",
                   a, core_wait, core_out);
        end
        done = 1'b1;
      end else begin
        checks++;
        if (I_req !== 1'b1 || I_addr !== line || core_wait !== 1'b1) begin
          errors++;
          $display("FAIL miss %h: ireq=%b iaddr=%h wait=%b, expected ireq=1 iaddr=%h wait=1",
                   a, I_req, I_addr, core_wait, line);
        end
        if (I_req === 1'b1) begin n_ref++; req_cyc++; end
        exp_miss++;
        v = !m_valid[0][s] ? 0 : (!m_valid[1][s] ? 1 : int'(m_lru[s]));
        m_valid[v][s] = 1'b0;
        m_tag[v][s] = a[31:10];
        nb = (round == 0 && early > 0) ? early : 4;
        @(posedge clk); #1;
        for (int b = 0; b < nb; b++) begin
          gap = gaps ? $urandom_range(0, 2) : 0;
          for (int g = 0; g <= gap; g++) begin
            checks++;
            if (I_req !== 1'b1 || I_addr !== line) begin
              errors++;
              $display("FAIL refill_req %h beat %0d: ireq=%b iaddr=%h, expected ireq=1 iaddr=%h",
                       a, b, I_req, I_addr, line);
            end
            if (I_req === 1'b1) req_cyc++;
            if (g == gap) begin
              RVALID = 1'b1; I_out = mem_word(line + 32'(4 * b));
              RLAST = (b == nb - 1);
            end
            @(posedge clk); #1;
            RVALID = 1'b0; RLAST = 1'b0;
          end
        end
        checks++;
        if (I_req !== 1'b0 || core_wait !== 1'b1) begin
          errors++;
          $display("FAIL fill_done %h: ireq=%b wait=%b, expected ireq=0 wait=1",
                   a, I_req, core_wait);
        end
        if (nb == 4) m_valid[v][s] = 1'b1;
        m_lru[s] = ~v[0];
        @(posedge clk); #1;
        round++;
      end
    end
  endtask

  task automatic do_inv(input bit with_req);
    core_req = with_req; core_addr = 32'h0; inv = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (core_wait !== 1'b0 || I_req !== 1'b0 || core_out !== 32'h0) begin
      errors++;
      $display("FAIL inv_cycle: wait=%b ireq=%b out=%h, expected wait=0 ireq=0 out=0",
               core_wait, I_req, core_out);
    end
    inv = 1'b0; core_req = 1'b0;
    model_clear();
    @(posedge clk); #1;
    checks++;
    if (core_wait !== 1'b1) begin
      errors++;
      $display("FAIL inv_exit: wait=%b, expected 1", core_wait);
    end
  endtask

  task automatic check_stats(input string tag);
    logic [31:0] eh, em;
`ifdef L1C_INST_STATS_EN
    eh = 32'(exp_hit); em = 32'(exp_miss);
`else
    eh = 32'h0; em = 32'h0;
`endif
    checks++;
    if (hit_cnt !== eh || miss_cnt !== em) begin
      errors++;
      $display("FAIL stats_%s: hit=%0d miss=%0d, expected hit=%0d miss=%0d",
               tag, hit_cnt, miss_cnt, eh, em);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; core_req = 1'b0; inv = 1'b0; stall_DM = 1'b0;
    core_addr = 32'h0; I_out = 32'h0; RVALID = 1'b0; RLAST = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (core_wait !== 1'b1 || core_out !== 32'h0 || I_req !== 1'b0 || I_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: wait=%b out=%h ireq=%b iaddr=%h, expected 1/0/0/0",
               core_wait, core_out, I_req, I_addr);
    end
    model_clear(); exp_hit = 0; exp_miss = 0;
    check_stats("reset");
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    int nr, rc;
    do_fetch(32'h0000_0104, 0, 0, 1'b0, 1'b0, nr, rc);
    checks++;
    if (nr !== 1 || rc !== 5) begin
      errors++;
      $display("FAIL cold_miss: refills=%0d ireq_cycles=%0d, expected 1 and 5", nr, rc);
    end
  endtask

  task automatic test_hit_stall();
    int nr, rc;
    do_fetch(32'h0000_0108, 0, 3, 1'b0, 1'b0, nr, rc);
    checks++;
    if (nr !== 0) begin
      errors++;
      $display("FAIL hit_no_refill: refills=%0d, expected 0", nr);
    end
  endtask

  task automatic test_lru_evict();
    int nr, rc;
    do_fetch(32'h0000_0000, 0, 0, 1'b1, 1'b0, nr, rc);
    do_fetch(32'h0000_0400, 0, 0, 1'b1, 1'b0, nr, rc);
    do_fetch(32'h0000_0004, 0, 0, 1'b0, 1'b0, nr, rc);
    do_fetch(32'h0000_0800, 0, 0, 1'b1, 1'b0, nr, rc);
    do_fetch(32'h0000_0000, 0, 0, 1'b0, 1'b0, nr, rc);
    checks++;
    if (nr !== 0) begin
      errors++;
      $display("FAIL lru_keep_0000: refills=%0d, expected 0", nr);
    end
    do_fetch(32'h0000_0400, 0, 0, 1'b0, 1'b0, nr, rc);
    checks++;
    if (nr !== 1) begin
      errors++;
      $display("FAIL lru_evicted_0400: refills=%0d, expected 1", nr);
    end
  endtask

  task automatic test_early_rlast();
    int nr, rc;
    do_fetch(32'h0000_0208, 2, 0, 1'b0, 1'b0, nr, rc);
    checks++;
    if (nr !== 2) begin
      errors++;
      $display("FAIL early_rlast: refills=%0d, expected 2", nr);
    end
  endtask

  task automatic test_inv();
    int nr, rc;
    do_inv(1'b1);
    do_fetch(32'h0000_0000, 0, 0, 1'b0, 1'b0, nr, rc);
    checks++;
    if (nr !== 1) begin
      errors++;
      $display("FAIL inv_then_miss: refills=%0d, expected 1", nr);
    end
    check_stats("after_inv");
  endtask

  task automatic test_reset_mid_refill();
    int nr, rc;
    core_addr = 32'h0000_0340; core_req = 1'b1;
    @(posedge clk); #1;
    core_req = 1'b0;
    @(posedge clk); #1;
    RVALID = 1'b1; I_out = mem_word(32'h340);
    @(posedge clk); #1;
    RVALID = 1'b1; I_out = mem_word(32'h344); rst = 1'b1;
    @(posedge clk); #1;
    RVALID = 1'b0; rst = 1'b0;
    checks++;
    if (core_wait !== 1'b1 || I_req !== 1'b0 || I_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_refill: wait=%b ireq=%b iaddr=%h, expected 1/0/0",
               core_wait, I_req, I_addr);
    end
    model_clear(); exp_hit = 0; exp_miss = 0;
    check_stats("after_reset");
    RVALID = 1'b1; I_out = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    RLAST = 1'b1;
    @(posedge clk); #1;
    RVALID = 1'b0; RLAST = 1'b0;
    do_fetch(32'h0000_0340, 0, 0, 1'b0, 1'b0, nr, rc);
    checks++;
    if (nr !== 1) begin
      errors++;
      $display("FAIL post_reset_miss: refills=%0d, expected 1", nr);
    end
  endtask

  task automatic test_random();
    int nr, rc;
    logic [31:0] a;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_inv($urandom_range(0, 1) == 1);
      end else begin
        a = (32'($urandom_range(0, 5)) << 10) | (32'($urandom_range(0, 3)) << 4)
            | (32'($urandom_range(0, 3)) << 2);
        do_fetch(a, 0, $urandom_range(0, 2), 1'b1, 1'b1, nr, rc);
      end
    end
    check_stats("random");
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_stall();
    test_lru_evict();
    test_early_rlast();
    test_inv();
    test_reset_mid_refill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
